// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the pipelined adder family.
//   nseg()  : number of SEG-bit pipeline segments in a WIDTH-bit word
//   OP_ADD / OP_SUB : encoding of the sub mode input
package arith_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Stage count for a WIDTH-bit adder resolved SEG bits per stage.
  function automatic int unsigned nseg(input int unsigned width, input int unsigned seg);
    return width / seg;
  endfunction

endpackage

// File: rtl/pipelined_adder_n_if.sv
// Operand/result handshake bundle for pipelined_adder_n.
//   in_valid/in_ready   : operand beat handshake (a, b, cin, sub)
//   out_valid/out_ready : result beat handshake (s, carry, ovf)
// master = producer/consumer side, slave = the adder.
interface pipelined_adder_n_if #(
  parameter int unsigned WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             carry;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, carry, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, carry, ovf
  );

endinterface

// File: rtl/adder_seg_stage.sv
// One pipeline stage of the segmented adder: resolves bits
// [IDX*SEG +: SEG] of the sum and registers the carry for the next stage.
//   ld        : stage may load this cycle (empty or its content moves on)
//   up_*      : upstream valid, operands, partial sum and carry
//   valid/a/b/sum/c : registered stage content
module adder_seg_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEG   = 8,
  parameter int unsigned IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_a,
  input  logic [WIDTH-1:0] up_b,
  input  logic [WIDTH-1:0] up_sum,
  input  logic             up_c,
  output logic             valid,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             c
);

  localparam int unsigned LO = IDX * SEG;
  localparam int unsigned SW = SEG + 1;

  logic [SEG:0]       seg_res;
  logic [WIDTH-1:0]   sum_c;

  // Segment add; lower resolved bits and upper operand bits pass unchanged.
  always_comb begin
    seg_res = {1'b0, up_a[LO +: SEG]} + {1'b0, up_b[LO +: SEG]} + SW'(up_c);
    sum_c   = up_sum;
    sum_c[LO +: SEG] = seg_res[SEG-1:0];
  end

  // Data only updates on a real beat so a drained stage keeps its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      a     <= '0;
      b     <= '0;
      sum   <= '0;
      c     <= 1'b0;
    end else if (ld) begin
      valid <= up_valid;
      if (up_valid) begin
        a   <= up_a;
        b   <= up_b;
        sum <= sum_c;
        c   <= seg_res[SEG];
      end
    end
  end

endmodule

// File: rtl/pipelined_adder_n.sv
// Pipelined WIDTH-bit adder/subtractor, SEG bits resolved per stage,
// NSEG = WIDTH/SEG stages, latency NSEG, one beat per cycle.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of pipelined_adder_n_if (operands in, result out)
// Results come straight from the last stage registers.
module pipelined_adder_n
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEG   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipelined_adder_n_if.slave   bus
);

  localparam int unsigned NSEG = nseg(WIDTH, SEG);
  localparam int unsigned LAST = NSEG - 1;

  logic [NSEG-1:0]  v;
  logic [NSEG-1:0]  ld;
  logic [NSEG-1:0]  c_q;
  logic [WIDTH-1:0] a_q [NSEG];
  logic [WIDTH-1:0] b_q [NSEG];
  logic [WIDTH-1:0] s_q [NSEG];
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  // Subtraction as a + ~b + 1; cin is ignored in that mode.
  always_comb begin
    b_eff = bus.b;
    c_eff = bus.cin;
    if (bus.sub == OP_SUB) begin
      b_eff = ~bus.b;
      c_eff = 1'b1;
    end
  end

  // Ready chain from the output back: a stage loads when empty or when its
  // content moves on, so bubbles collapse under a stalled output.
  always_comb begin
    ld       = '0;
    ld[LAST] = !v[LAST] || bus.out_ready;
    for (int k = int'(NSEG) - 2; k >= 0; k--) begin
      ld[k] = !v[k] || ld[k+1];
    end
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    if (k == 0) begin : g_first
      adder_seg_stage #(.WIDTH(WIDTH), .SEG(SEG), .IDX(0)) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld       (ld[0]),
        .up_valid (bus.in_valid),
        .up_a     (bus.a),
        .up_b     (b_eff),
        .up_sum   ('0),
        .up_c     (c_eff),
        .valid    (v[0]),
        .a        (a_q[0]),
        .b        (b_q[0]),
        .sum      (s_q[0]),
        .c        (c_q[0])
      );
    end else begin : g_next
      adder_seg_stage #(.WIDTH(WIDTH), .SEG(SEG), .IDX(k)) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld       (ld[k]),
        .up_valid (v[k-1]),
        .up_a     (a_q[k-1]),
        .up_b     (b_q[k-1]),
        .up_sum   (s_q[k-1]),
        .up_c     (c_q[k-1]),
        .valid    (v[k]),
        .a        (a_q[k]),
        .b        (b_q[k]),
        .sum      (s_q[k]),
        .c        (c_q[k])
      );
    end
  end

  assign bus.in_ready  = ld[0];
  assign bus.out_valid = v[LAST];
  assign bus.s         = s_q[LAST];
  assign bus.carry     = c_q[LAST];
  // Signed overflow against the effective (possibly inverted) B operand.
  assign bus.ovf       = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &&
                         (s_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);

endmodule

// File: doc/pipelined_adder_n.md
Name: pipelined_adder_n

Overview:
- Parametrised, pipelined carry-chain adder/subtractor. It is the successor to the fixed 16-bit ripple adder built from 4-bit slices.
- The WIDTH-bit operation is split into SEG-bit segments. One segment is resolved per pipeline stage, and the carry is registered between stages.
- Valid/ready handshake on input and output, with bubble-collapsing backpressure.
- Sits in the datapath of the fast-multiplier family as the final carry-propagate adder, or as a standalone arithmetic unit.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of SEG.
- SEG, 8, bits resolved per stage; NSEG = WIDTH/SEG stages; NSEG >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts a beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in (ignored when sub=1)
- sub  input  1  0: s=a+b+cin; 1: s=a-b (internally a+~b+1)
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts result
- s  output  WIDTH  sum/difference
- carry  output  1  carry-out of MSB; for sub, 1 means no borrow
- ovf  output  1  signed overflow: (a_msb == b'_msb) && (s_msb != a_msb), where b' is the effective (possibly inverted) B

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits cleared.
  - out_valid=0; s, carry and ovf read 0.
  - Data registers need no reset but are zeroed for determinism.
- Accept: a beat is transferred when in_valid && in_ready.
- Capture on accept:
  - Stage 0 stores a, effective b (b, or ~b when sub=1) and effective cin (cin, or 1 when sub=1).
  - Stage 0 resolves segment 0, storing sum[SEG-1:0] and the registered carry.
- Stage k (1..NSEG-1):
  - Adds segment k of the carried operands plus the carry from stage k-1.
  - Stores the new segment result and carry.
  - Passes already-resolved low segments and unresolved high operand segments forward unchanged (operand skew).
- Output: the last stage drives s, carry and ovf directly from registers, with no combinational path from a/b to s.
- Latency: exactly NSEG cycles from accept to out_valid with an unstalled pipe. NSEG=1 gives latency 1.
- Throughput: one beat per cycle when out_ready is held high.
- Advance rules:
  - adv[NSEG-1] = out_ready || !valid[NSEG-1].
  - adv[k] = !valid[k+1] || adv[k+1].
  - in_ready = !valid[0] || adv[0].
  - A stalled stage holds its data; an empty stage is filled even while downstream stalls (bubble collapse).
- Capacity: NSEG beats in flight. in_ready falls only when all stages are valid and out_ready=0.
- Handshake rules:
  - out_valid, once high, stays high with s, carry and ovf stable until out_ready is sampled high.
  - in_ready may depend combinationally on out_ready; out_valid must not depend on in_valid.
- Simultaneous events: accept and emit in the same cycle with a full pipe is legal and keeps occupancy constant.
- Width rules: all arithmetic is modulo 2^WIDTH. carry is bit WIDTH of the full sum. ovf is computed in the last stage from the stored MSBs.
- Reset mid-operation: in-flight beats are discarded and no partial result is ever presented. After rst_n rises, the first beat appears after NSEG cycles.

Decomposition:
- Shared package (arith_pkg):
  - Localparam function nseg(WIDTH,SEG).
  - Mode encoding constants OP_ADD=0 and OP_SUB=1.
- One sub-module: adder_seg_stage.
  - Contents: one pipeline register stage holding valid, operand remainder, resolved sum bits and carry, plus the SEG-bit segment add.
  - Parametrised by WIDTH, SEG and stage index; instantiated NSEG times with a generate loop.
- Top level holds only input inversion for sub, the ready chain and the ovf computation.

Test Plan:
- WIDTH=32, SEG=8: a=0xFFFFFFFF, b=0, cin=1, sub=0, out_ready=1 -> exactly 4 cycles later s=0x00000000, carry=1, ovf=0.
- sub=1, a=5, b=7 -> s=0xFFFFFFFE, carry=0, ovf=0. Then a=0x80000000, b=1, sub=1 -> s=0x7FFFFFFF, carry=1, ovf=1.
- a=0x7FFFFFFF, b=1, cin=0 -> s=0x80000000, ovf=1, carry=0. Back-to-back stream of 10 random beats with out_ready=1 -> 10 results on consecutive cycles, order preserved, all match the reference model.
- Backpressure: out_ready=0, in_valid=1 continuously -> exactly 4 beats accepted, then in_ready=0 and out_valid=1 with s held stable. Raise out_ready -> one beat drains per cycle, no loss or duplication.
- Bubble collapse: inject beats on cycles 0 and 3 with out_ready low from cycle 2 -> both beats packed in the last two stages, in_ready stays 1.
- Reset: assert rst_n=0 for 1 cycle while 3 beats are in flight -> out_valid=0 immediately and the beats never appear. Post-reset beat a=1, b=2 -> s=3 after 4 cycles. Repeat with WIDTH=16, SEG=16 (latency 1) and WIDTH=64, SEG=4 (latency 16).
